// File: rtl/str2int_pkg.sv
// Shared state encoding and BCD/ASCII constants for the str2int BCD-to-binary converter.
package str2int_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] BCD_CORR_THR = 4'd8;
  localparam logic [3:0] BCD_CORR     = 4'd3;
  localparam logic [7:0] ASCII_ZERO   = 8'h30;
  localparam logic [7:0] ASCII_NINE   = 8'h39;

endpackage

// File: rtl/str2int_bcd_shr_corr.sv
// Per-digit correction applied after each right shift of the BCD register.
module bcd_shr_corr
  import str2int_pkg::*;
(
  input  logic [3:0] iDigit,
  output logic [3:0] oDigit
);

  assign oDigit = (iDigit >= BCD_CORR_THR) ? (iDigit - BCD_CORR) : iDigit;

endmodule

// File: rtl/str2int.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one iteration per clock).
// Define STR2INT_ASCII_EN to accept one ASCII character per digit instead of packed BCD.
//
// state | meaning
// IDLE  | waiting for iStart
// SHIFT | conversion in progress
// DONE  | result (or error) held on outputs
module str2int
  import str2int_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 16
) (
  input  logic                iClock,
  input  logic                iReset,
  input  logic                iStart,
`ifdef STR2INT_ASCII_EN
  input  logic [8*DIGITS-1:0] iString,
`else
  input  logic [4*DIGITS-1:0] iString,
`endif
  output logic [BIN_W-1:0]    oBinary,
  output logic                oDone,
  output logic                oError
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  state_t           state;
  logic [BCD_W-1:0] bcdReg;
  logic [BIN_W-1:0] binReg;
  logic [CNT_W-1:0] iterCnt;

  logic [BCD_W-1:0] capBcd;
  logic             capErr;

  // Reduce the input to BCD nibbles and flag any digit that is not 0..9.
  always_comb begin
    capBcd = '0;
    capErr = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
`ifdef STR2INT_ASCII_EN
      if ((iString[8*i +: 8] < ASCII_ZERO) || (iString[8*i +: 8] > ASCII_NINE))
        capErr = 1'b1;
      capBcd[4*i +: 4] = iString[8*i +: 4];
`else
      if (iString[4*i +: 4] > BCD_MAX)
        capErr = 1'b1;
      capBcd[4*i +: 4] = iString[4*i +: 4];
`endif
    end
  end

  logic [BCD_W+BIN_W-1:0] shifted;
  logic [BCD_W-1:0]       bcdShr;
  logic [BCD_W-1:0]       bcdNext;
  logic [BIN_W-1:0]       binNext;

  assign shifted = {bcdReg, binReg} >> 1;
  assign bcdShr  = shifted[BCD_W+BIN_W-1:BIN_W];
  assign binNext = shifted[BIN_W-1:0];

  for (genvar i = 0; i < DIGITS; i++) begin : digit_array
    bcd_shr_corr uCorr (
      .iDigit (bcdShr[4*i +: 4]),
      .oDigit (bcdNext[4*i +: 4])
    );
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state   <= IDLE;
      oBinary <= '0;
      oDone   <= 1'b0;
      oError  <= 1'b0;
      iterCnt <= '0;
      bcdReg  <= '0;
      binReg  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (iStart) begin
            if (capErr) begin
              state   <= DONE;
              oDone   <= 1'b1;
              oError  <= 1'b1;
              oBinary <= '0;
            end else begin
              state   <= SHIFT;
              oDone   <= 1'b0;
              oError  <= 1'b0;
              bcdReg  <= capBcd;
              binReg  <= '0;
              iterCnt <= '0;
            end
          end
        end
        SHIFT: begin
          bcdReg  <= bcdNext;
          binReg  <= binNext;
          iterCnt <= iterCnt + 1'b1;
          if (iterCnt == LAST_ITER) begin
            oBinary <= binNext;
            oDone   <= 1'b1;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
